filter_mode_sequencer: RTL and testbench
========================================

FILTER_MODE_SEQUENCER -- requirements
Module: filter_mode_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 24, audio sample width.
REQ-002 SHALL have parameter SETTLE_EXTRA, default 2, samples added to tap count to cover filter output register latency.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sample_en  input  1  one-clk strobe marking a new audio sample.
REQ-006 SHALL have port req_valid  input  1  mode change request valid.
REQ-007 SHALL have port req_mode  input  3  requested filter mode.
REQ-008 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-009 SHALL have port filt_sel  output  3  mode driven to the averaging filter.
REQ-010 SHALL have port q_in  input  BIT_WIDTH  signed filter output.
REQ-011 SHALL have port q_out  output  BIT_WIDTH  signed click-free output sample.
REQ-012 SHALL have port settling  output  1  high while output is held during flush.
REQ-013 SHALL have port done  output  1  one-clk pulse when a request completes.

Function
REQ-014 SHALL implement two states: RUN and SETTLE; req_ready = 1 in RUN only, settling = 1 in SETTLE only.
REQ-015 SHALL accept a request on a clk edge where req_valid and req_ready are both 1; req_mode sampled on that edge only.
REQ-016 SHALL, on accept with req_mode == filt_sel, stay in RUN and pulse done the next cycle; filt_sel and q_out unaffected.
REQ-017 SHALL, on accept with req_mode != filt_sel, register filt_sel <= req_mode, load settle counter with SETTLE_TAB[req_mode], enter SETTLE.
REQ-018 SHALL use SETTLE_TAB = taps + SETTLE_EXTRA with taps 000:1, 001:2, 010:4, 011:8, 100:16, 101:4, 110:5, 111:4 (default 3,4,6,10,18,6,7,6).
REQ-019 SHALL in RUN update q_out <= q_in on every sample_en, including the accept cycle (old mode data still valid).
REQ-020 SHALL in SETTLE hold q_out unchanged and decrement the counter on each sample_en; a sample_en coinciding with the accept edge is not counted.
REQ-021 SHALL, on the sample_en that brings the counter from 1 to 0, return to RUN and pulse done; q_out resumes on the next sample_en after that (that strobe itself does not update q_out).
REQ-022 SHALL ignore req_valid during SETTLE (req_ready = 0); a held request is accepted the first RUN cycle.
REQ-023 SHALL keep counter width 5 bits; counter never wraps (no decrement at 0).
REQ-024 SHALL hold state indefinitely in SETTLE if sample_en never arrives; no timeout.

Reset
REQ-025 SHALL on reset_n = 0 at a clk edge set state RUN, filt_sel 3'b000, q_out 0, counter 0, done 0, settling 0, req_ready 1.
REQ-026 SHALL, on reset mid-SETTLE, abort the flush without a done pulse and restart as REQ-025.
REQ-027 SHALL give reset priority over request acceptance and sample_en.

Structure
REQ-028 SHALL place mode encodings (BYPASS, AVG2, AVG4, AVG8, AVG16, WGT4, WGT5, WGT_DEF), state enum and SETTLE_TAB in shared package filter_ctrl_pkg.
REQ-029 SHALL contain one sub-module settle_counter (load, sample-strobe decrement, zero flag); otherwise flat.

Verification
REQ-030 Reset then sample_en every 4 clk, q_in = 100 -> filt_sel 000, q_out = 100 after first strobe, req_ready 1.
REQ-031 Request 011 from 000, q_in steps 100 -> 500 -> settling 1 for exactly 10 sample_en, q_out holds 100, done pulse on 10th, q_out = 500 at 11th strobe.
REQ-032 Request 010 while filt_sel = 010 -> done next clk, settling never asserts, q_out keeps tracking.
REQ-033 req_valid held with mode 100 during SETTLE of mode 001 -> not accepted until RUN, then 18-sample settle, filt_sel 100.
REQ-034 Accept edge coincident with sample_en, q_in = -7 -> q_out = -7, counter still loaded with full table value.
REQ-035 reset_n low for one clk at settle count 3 -> no done, filt_sel 000, q_out 0, req_ready 1 next cycle.

Source files
------------

// File: rtl/filter_ctrl_pkg.sv
// Shared definitions for the averaging-filter control path: mode encodings,
// sequencer states and the per-mode settle length.
package filter_ctrl_pkg;

    localparam int MODE_W = 3;
    localparam int CNT_W  = 5;

    typedef enum logic [MODE_W-1:0] {
        BYPASS  = 3'd0,
        AVG2    = 3'd1,
        AVG4    = 3'd2,
        AVG8    = 3'd3,
        AVG16   = 3'd4,
        WGT4    = 3'd5,
        WGT5    = 3'd6,
        WGT_DEF = 3'd7
    } filt_mode_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } seq_state_t;

    // SETTLE_TAB: filter tap count plus the extra samples for output register latency.
    function automatic logic [CNT_W-1:0] settle_tab(input logic [MODE_W-1:0] mode, input int extra);
        int taps;
        taps = 1;
        case (mode)
            BYPASS:  taps = 1;
            AVG2:    taps = 2;
            AVG4:    taps = 4;
            AVG8:    taps = 8;
            AVG16:   taps = 16;
            WGT4:    taps = 4;
            WGT5:    taps = 5;
            WGT_DEF: taps = 4;
            default: taps = 1;
        endcase
        return CNT_W'(taps + extra);
    endfunction

endpackage

// File: rtl/filter_mode_sequencer_settle_counter.sv
// Flush length counter: loads a sample count, counts down on sample strobes
// and saturates at zero.
module settle_counter
    import filter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);
    assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/filter_mode_sequencer.sv
// Switches the averaging filter mode and freezes the output while the filter
// pipeline refills, so a mode change never produces an audible click.
module filter_mode_sequencer
    import filter_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH    = 24,
    parameter int SETTLE_EXTRA = 2
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sample_en,
    input  logic                        req_valid,
    input  logic [MODE_W-1:0]           req_mode,
    output logic                        req_ready,
    output logic [MODE_W-1:0]           filt_sel,
    input  logic signed [BIT_WIDTH-1:0] q_in,
    output logic signed [BIT_WIDTH-1:0] q_out,
    output logic                        settling,
    output logic                        done
);

    seq_state_t                  state_reg, state_next;
    logic [MODE_W-1:0]           filt_sel_reg, filt_sel_next;
    logic signed [BIT_WIDTH-1:0] q_out_reg, q_out_next;
    logic                        done_reg, done_next;

    logic             accept;
    logic             mode_change;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             cnt_last;
    logic             finish;
    logic [CNT_W-1:0] settle_len;

    assign accept      = req_valid && (state_reg == ST_RUN);
    assign mode_change = accept && (req_mode != filt_sel_reg);
    assign settle_len  = settle_tab(req_mode, SETTLE_EXTRA);
    // The accept edge itself never decrements: the counter is only enabled in SETTLE.
    assign cnt_dec     = sample_en && (state_reg == ST_SETTLE);
    assign finish      = cnt_dec && (cnt_last || cnt_zero);

    settle_counter u_settle_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (mode_change),
        .load_val (settle_len),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_next    = state_reg;
        filt_sel_next = filt_sel_reg;
        q_out_next    = q_out_reg;
        done_next     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                // Old-mode data is still valid on the accept cycle.
                if (sample_en) begin
                    q_out_next = q_in;
                end
                if (mode_change) begin
                    filt_sel_next = req_mode;
                    state_next    = ST_SETTLE;
                end else if (accept) begin
                    done_next = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (finish) begin
                    state_next = ST_RUN;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_RUN;
            filt_sel_reg <= '0;
            q_out_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            filt_sel_reg <= filt_sel_next;
            q_out_reg    <= q_out_next;
            done_reg     <= done_next;
        end
    end

    assign req_ready = (state_reg == ST_RUN);
    assign settling  = (state_reg == ST_SETTLE);
    assign filt_sel  = filt_sel_reg;
    assign q_out     = q_out_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Bench for filter_mode_sequencer: directed scenarios plus a randomized run,
// all checked against a sample-count reference model.
module tb_filter_mode_sequencer;

    localparam int BW    = 24;
    localparam int EXTRA = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 sample_en;
    logic                 req_valid;
    logic [2:0]           req_mode;
    logic                 req_ready;
    logic [2:0]           filt_sel;
    logic signed [BW-1:0] q_in;
    logic signed [BW-1:0] q_out;
    logic                 settling;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    // Reference model: current mode, strobes left in the flush, held output, done pulse.
    int                   m_mode = 0;
    int                   m_left = 0;
    logic signed [BW-1:0] m_q    = '0;
    bit                   m_done = 1'b0;

    filter_mode_sequencer #(.BIT_WIDTH(BW), .SETTLE_EXTRA(EXTRA)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .filt_sel  (filt_sel),
        .q_in      (q_in),
        .q_out     (q_out),
        .settling  (settling),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int settle_len(input int mode);
        int taps [8] = '{1, 2, 4, 8, 16, 4, 5, 4};
        return taps[mode] + EXTRA;
    endfunction

    // One clock edge; the model consumes the same inputs the DUT saw on that edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_mode = 0;
            m_left = 0;
            m_q    = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
                if (sample_en) m_q = q_in;
                if (req_valid) begin
                    if (int'(req_mode) == m_mode) begin
                        m_done = 1'b1;
                    end else begin
                        m_mode = int'(req_mode);
                        m_left = settle_len(m_mode);
                    end
                end
            end else if (sample_en) begin
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end
        #1;
    endtask

    // One audio sample period: strobe on the first clk, then three idle clks.
    task automatic strobe(input logic signed [BW-1:0] v, output bit was_settling, output bit got_done);
        was_settling = settling;
        q_in = v;
        sample_en = 1'b1;
        tick();
        got_done = done;
        sample_en = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Keep sampling until the flush ends; n stops at 40 if it never does.
    task automatic flush(input logic signed [BW-1:0] v, output int n);
        bit ws, gd;
        n = 0;
        while (settling === 1'b1 && n < 40) begin
            strobe(v, ws, gd);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_en = 1'b1; req_valid = 1'b1; req_mode = 3'd5; q_in = 55;
        tick();
        tick();
        checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL reset_filt_sel actual=%0d required=0", filt_sel); end
        checks++; if (q_out !== '0) begin failures++; $display("FAIL reset_q_out actual=%0d required=0", q_out); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready actual=%b required=1", req_ready); end
        checks++; if (settling !== 1'b0) begin failures++; $display("FAIL reset_settling actual=%b required=0", settling); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
        reset_n = 1'b1; sample_en = 1'b0; req_valid = 1'b0; req_mode = 3'd0;
        tick();
        $display("[tb] reset applied");
    endtask

    task automatic test_basic();
        bit ws, gd;
        strobe(100, ws, gd);
        checks++; if (q_out !== 24'sd100) begin failures++; $display("FAIL basic_q_out actual=%0d required=100", q_out); end
        checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL basic_filt_sel actual=%0d required=0", filt_sel); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_req_ready actual=%b required=1", req_ready); end
        $display("[tb] sample 100 passed through in mode 0");
    endtask

    task automatic test_mode_change();
        bit ws, gd;
        int n_settle, n_done, done_at;
        req_valid = 1'b1; req_mode = 3'd3;
        tick();
        req_valid = 1'b0;
        checks++; if (settling !== 1'b1) begin failures++; $display("FAIL chg_settling actual=%b required=1", settling); end
        checks++; if (filt_sel !== 3'd3) begin failures++; $display("FAIL chg_filt_sel actual=%0d required=3", filt_sel); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL chg_req_ready actual=%b required=0", req_ready); end
        n_settle = 0; n_done = 0; done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            strobe(500, ws, gd);
            if (ws) n_settle++;
            if (gd) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
            checks++; if (q_out !== 24'sd100) begin failures++; $display("FAIL chg_hold_q_out strobe=%0d actual=%0d required=100", i, q_out); end
        end
        checks++; if (n_settle != 10) begin failures++; $display("FAIL chg_settle_strobes actual=%0d required=10", n_settle); end
        checks++; if (n_done != 1 || done_at != 10) begin failures++; $display("FAIL chg_done_pulse actual=%0d@%0d required=1@10", n_done, done_at); end
        checks++; if (settling !== 1'b0) begin failures++; $display("FAIL chg_end_settling actual=%b required=0", settling); end
        strobe(500, ws, gd);
        checks++; if (q_out !== 24'sd500) begin failures++; $display("FAIL chg_resume_q_out actual=%0d required=500", q_out); end
        $display("[tb] mode 0->3 settled over %0d strobes", n_settle);
    endtask

    task automatic test_same_mode();
        bit ws, gd;
        bit saw_settle;
        int n;
        logic signed [BW-1:0] v;
        req_valid = 1'b1; req_mode = 3'd2;
        tick();
        req_valid = 1'b0;
        flush(-20, n);
        checks++; if (n != 6) begin failures++; $display("FAIL same_setup_strobes actual=%0d required=6", n); end
        req_valid = 1'b1; req_mode = 3'd2;
        tick();
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL same_done actual=%b required=1", done); end
        checks++; if (settling !== 1'b0) begin failures++; $display("FAIL same_settling actual=%b required=0", settling); end
        checks++; if (filt_sel !== 3'd2) begin failures++; $display("FAIL same_filt_sel actual=%0d required=2", filt_sel); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL same_done_width actual=%b required=0", done); end
        saw_settle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = BW'($urandom);
            strobe(v, ws, gd);
            if (ws || settling) saw_settle = 1'b1;
            checks++; if (q_out !== v) begin failures++; $display("FAIL same_track_q_out actual=%0d required=%0d", q_out, v); end
        end
        checks++; if (saw_settle) begin failures++; $display("FAIL same_no_settle actual=1 required=0"); end
        $display("[tb] same-mode request 2 completed immediately");
    endtask

    task automatic test_held_request();
        bit ws, gd;
        int n;
        req_valid = 1'b1; req_mode = 3'd1;
        tick();
        req_mode = 3'd4;
        for (int i = 1; i <= 4; i++) begin
            strobe(BW'(i * 10), ws, gd);
            if (i < 4) begin
                checks++; if (filt_sel !== 3'd1) begin failures++; $display("FAIL held_ignored strobe=%0d actual=%0d required=1", i, filt_sel); end
            end
        end
        checks++; if (filt_sel !== 3'd4) begin failures++; $display("FAIL held_accepted actual=%0d required=4", filt_sel); end
        checks++; if (settling !== 1'b1) begin failures++; $display("FAIL held_settling actual=%b required=1", settling); end
        req_valid = 1'b0;
        flush(77, n);
        checks++; if (n != 18) begin failures++; $display("FAIL held_settle_strobes actual=%0d required=18", n); end
        $display("[tb] held request 4 accepted after flush, settled over %0d strobes", n);
    endtask

    task automatic test_coincident();
        int n;
        logic signed [BW-1:0] exp_q;
        exp_q = -7;
        q_in = exp_q; sample_en = 1'b1; req_valid = 1'b1; req_mode = 3'd5;
        tick();
        sample_en = 1'b0; req_valid = 1'b0;
        checks++; if (q_out !== exp_q) begin failures++; $display("FAIL coin_q_out actual=%0d required=-7", q_out); end
        checks++; if (settling !== 1'b1) begin failures++; $display("FAIL coin_settling actual=%b required=1", settling); end
        flush(123, n);
        checks++; if (n != 6) begin failures++; $display("FAIL coin_settle_strobes actual=%0d required=6", n); end
        checks++; if (q_out !== exp_q) begin failures++; $display("FAIL coin_held_q_out actual=%0d required=-7", q_out); end
        $display("[tb] request 5 on a sample strobe, settled over %0d strobes", n);
    endtask

    task automatic test_reset_mid_settle();
        bit ws, gd;
        bit saw_done;
        req_valid = 1'b1; req_mode = 3'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) strobe(9, ws, gd);
        checks++; if (settling !== 1'b1) begin failures++; $display("FAIL rmid_pre_settling actual=%b required=1", settling); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done actual=%b required=0", done); end
        checks++; if (filt_sel !== 3'd0) begin failures++; $display("FAIL rmid_filt_sel actual=%0d required=0", filt_sel); end
        checks++; if (q_out !== '0) begin failures++; $display("FAIL rmid_q_out actual=%0d required=0", q_out); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_req_ready actual=%b required=1", req_ready); end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(0, ws, gd);
            if (gd) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL rmid_late_done actual=1 required=0"); end
        $display("[tb] reset during flush of mode 4 aborted it");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            sample_en = ($urandom_range(0, 2) == 0);
            req_valid = ($urandom_range(0, 3) == 0);
            req_mode  = 3'($urandom);
            q_in      = BW'($urandom);
            tick();
            checks++; if (filt_sel !== 3'(m_mode)) begin failures++; $display("FAIL rnd_filt_sel cyc=%0d actual=%0d required=%0d", i, filt_sel, m_mode); end
            checks++; if (q_out !== m_q) begin failures++; $display("FAIL rnd_q_out cyc=%0d actual=%0d required=%0d", i, q_out, m_q); end
            checks++; if (settling !== (m_left != 0)) begin failures++; $display("FAIL rnd_settling cyc=%0d actual=%b required=%b", i, settling, m_left != 0); end
            checks++; if (req_ready !== (m_left == 0)) begin failures++; $display("FAIL rnd_req_ready cyc=%0d actual=%b required=%b", i, req_ready, m_left == 0); end
            checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done cyc=%0d actual=%b required=%b", i, done, m_done); end
        end
        reset_n = 1'b1; sample_en = 1'b0; req_valid = 1'b0;
        $display("[tb] randomized run of 3000 cycles complete");
    endtask

    initial begin
        reset_n = 1'b0; sample_en = 1'b0; req_valid = 1'b0; req_mode = 3'd0; q_in = '0;
        test_reset();
        test_basic();
        test_mode_change();
        test_same_mode();
        test_held_request();
        test_coincident();
        test_reset_mid_settle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
